// File: rtl/mult_div_seq_pkg.sv
// rtl/mult_div_seq_pkg.sv - shared state encoding and op codes for the multiply-divide unit
package mult_div_seq_pkg;

    typedef logic [1:0] md_op_t;
    typedef logic [1:0] md_state_t;

    // op = {unsigned, is_div}; the control unit decodes with the same constants
    localparam md_op_t OP_MULT  = 2'b00;
    localparam md_op_t OP_DIV   = 2'b01;
    localparam md_op_t OP_MULTU = 2'b10;
    localparam md_op_t OP_DIVU  = 2'b11;

    localparam md_state_t ST_IDLE = 2'd0;
    localparam md_state_t ST_RUN  = 2'd1;
    localparam md_state_t ST_FIX  = 2'd2;
    localparam md_state_t ST_DZ   = 2'd3;

endpackage

// File: rtl/mult_div_seq_md_abs_neg.sv
// rtl/mult_div_seq_md_abs_neg.sv - conditional two's-complement negate (absolute value when neg_i = sign bit)
module md_abs_neg #(
    parameter int W = 32
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] res_o
);

    assign res_o = neg_i ? (-val_i) : val_i;

endmodule

// File: rtl/mult_div_seq.sv
// rtl/mult_div_seq.sv - iterative signed/unsigned multiply-divide unit writing the HI/LO pair
module mult_div_seq
    import mult_div_seq_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int UNSIGNED_EN = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    md_state_t          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   mag_q, mag_d;
    logic               is_div_q, is_div_d;
    logic               neg_q_q, neg_q_d;
    logic               neg_r_q, neg_r_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               signed_mode, sign_a, sign_b;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic [WIDTH:0]     addend, add_sum, shifted, diff;
    logic               ge;

    assign signed_mode = !((UNSIGNED_EN != 0) && op[1]);
    assign sign_a      = signed_mode & a_in[WIDTH-1];
    assign sign_b      = signed_mode & b_in[WIDTH-1];

    md_abs_neg #(.W(WIDTH))   u_abs_a    (.val_i(a_in),              .neg_i(sign_a),  .res_o(abs_a));
    md_abs_neg #(.W(WIDTH))   u_abs_b    (.val_i(b_in),              .neg_i(sign_b),  .res_o(abs_b));
    md_abs_neg #(.W(2*WIDTH)) u_fix_prod (.val_i(acc_q),             .neg_i(neg_q_q), .res_o(prod_fix));
    md_abs_neg #(.W(WIDTH))   u_fix_quo  (.val_i(acc_q[WIDTH-1:0]),  .neg_i(neg_q_q), .res_o(quo_fix));
    md_abs_neg #(.W(WIDTH))   u_fix_rem  (.val_i(rem_q),             .neg_i(neg_r_q), .res_o(rem_fix));

    // Multiply: upper half accumulates the multiplicand, whole pair shifts right each step.
    // Divide: restoring step; the quotient bit shifts into the low half as the dividend shifts out.
    assign addend  = acc_q[0] ? {1'b0, mag_q} : '0;
    assign add_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + addend;
    assign shifted = {rem_q, acc_q[WIDTH-1]};
    assign diff    = shifted - {1'b0, mag_q};
    assign ge      = ~diff[WIDTH];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        mag_d    = mag_q;
        is_div_d = is_div_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        dz_d     = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !done_q) begin
                    is_div_d = op[0];
                    neg_q_d  = sign_a ^ sign_b;
                    neg_r_d  = sign_a;
                    cnt_d    = CNT_W'(WIDTH);
                    rem_d    = '0;
                    busy_d   = 1'b1;
                    if (op[0] && (b_in == '0)) begin
                        state_d = ST_DZ;
                    end else begin
                        state_d = ST_RUN;
                        mag_d   = op[0] ? abs_b : abs_a;
                        acc_d   = {{WIDTH{1'b0}}, (op[0] ? abs_a : abs_b)};
                    end
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (is_div_q) begin
                    rem_d = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
                    acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], ge};
                end else begin
                    acc_d = {add_sum, acc_q[WIDTH-1:1]};
                end
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            ST_DZ: begin
                done_d  = 1'b1;
                dz_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            mag_q    <= '0;
            is_div_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            mag_q    <= mag_d;
            is_div_q <= is_div_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;
    assign hi_out   = hi_q;
    assign lo_out   = lo_q;

endmodule

// File: tb/tb_mult_div_seq.sv
// tb/tb_mult_div_seq.sv - randomized self-checking bench for mult_div_seq against an arithmetic model
module tb_mult_div_seq;
    import mult_div_seq_pkg::*;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a_in, b_in;
    logic         busy, done, div_zero;
    logic [W-1:0] hi_out, lo_out;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] ref_hi = '0;
    logic [W-1:0] ref_lo = '0;

    mult_div_seq #(.WIDTH(W), .UNSIGNED_EN(1)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a_in     (a_in),
        .b_in     (b_in),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi_out   (hi_out),
        .lo_out   (lo_out)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // HI/LO as the architecture defines them; divide-by-zero leaves them untouched
    task automatic ref_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic dz);
        longint     sa, sb, q, r;
        logic [63:0] p;
        dz = 1'b0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            OP_MULT: begin
                p = 64'(sa * sb);
                ref_hi = p[63:32];
                ref_lo = p[31:0];
            end
            OP_MULTU: begin
                p = 64'(a) * 64'(b);
                ref_hi = p[63:32];
                ref_lo = p[31:0];
            end
            OP_DIV: begin
                if (b == '0) dz = 1'b1;
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    ref_lo = q[31:0];
                    ref_hi = r[31:0];
                end
            end
            default: begin
                if (b == '0) dz = 1'b1;
                else begin
                    ref_lo = a / b;
                    ref_hi = a % b;
                end
            end
        endcase
    endtask

    task automatic wait_idle();
        int guard = 0;
        while ((busy || done) && guard < 100) begin
            @(posedge clock); #1;
            guard++;
        end
    endtask

    task automatic do_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] hi, output logic [W-1:0] lo,
                         output logic dz, output int lat, output logic busy0);
        wait_idle();
        start = 1'b1; op = o; a_in = a; b_in = b;
        @(posedge clock); #1;
        start = 1'b0;
        busy0 = busy;
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clock); #1;
            lat++;
        end
        hi = hi_out; lo = lo_out; dz = div_zero;
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] v;
        case ($urandom_range(0, 3))
            0: v = $urandom;
            1: begin
                v = W'($urandom_range(0, 20));
                if ($urandom_range(0, 1) == 1) v = -v;
            end
            2: case ($urandom_range(0, 4))
                   0: v = 32'h0000_0000;
                   1: v = 32'h0000_0001;
                   2: v = 32'hFFFF_FFFF;
                   3: v = 32'h8000_0000;
                   default: v = 32'h7FFF_FFFF;
               endcase
            default: v = $urandom;
        endcase
        return v;
    endfunction

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = '0; a_in = '0; b_in = '0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0)     begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL reset_dz: got %b want 0", div_zero); end
        checks++; if (hi_out !== '0)     begin errors++; $display("FAIL reset_hi: got %h want 0", hi_out); end
        checks++; if (lo_out !== '0)     begin errors++; $display("FAIL reset_lo: got %h want 0", lo_out); end
    endtask

    task automatic test_directed();
        logic [1:0]   t_op  [5] = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_DIV};
        logic [W-1:0] t_a   [5] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'h80000000};
        logic [W-1:0] t_b   [5] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd2, 32'h10, 32'hFFFFFFFF};
        logic [W-1:0] t_hi  [5] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0000000F, 32'h0};
        logic [W-1:0] t_lo  [5] = '{32'hFFFFFFEB, 32'h00000001, 32'hFFFFFFFD, 32'h0FFFFFFF, 32'h80000000};
        logic [W-1:0] hi, lo;
        logic         dz, b0, edz;
        int           lat;
        for (int i = 0; i < 5; i++) begin
            ref_op(t_op[i], t_a[i], t_b[i], edz);
            do_op(t_op[i], t_a[i], t_b[i], hi, lo, dz, lat, b0);
            checks++; if (b0 !== 1'b1)   begin errors++; $display("FAIL dir%0d_busy: got %b want 1", i, b0); end
            checks++; if (lat !== W + 1) begin errors++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, W + 1); end
            checks++; if (hi !== t_hi[i]) begin errors++; $display("FAIL dir%0d_hi: got %h want %h", i, hi, t_hi[i]); end
            checks++; if (lo !== t_lo[i]) begin errors++; $display("FAIL dir%0d_lo: got %h want %h", i, lo, t_lo[i]); end
            checks++; if (dz !== 1'b0)   begin errors++; $display("FAIL dir%0d_dz: got %b want 0", i, dz); end
        end
    endtask

    task automatic test_div_zero();
        logic [W-1:0] hi, lo;
        logic         dz, b0, edz;
        int           lat;
        ref_op(OP_DIV, 32'd5, 32'd0, edz);
        do_op(OP_DIV, 32'd5, 32'd0, hi, lo, dz, lat, b0);
        checks++; if (lat !== 1)     begin errors++; $display("FAIL dz_latency: got %0d want 1", lat); end
        checks++; if (dz !== 1'b1)   begin errors++; $display("FAIL dz_flag: got %b want 1", dz); end
        checks++; if (hi !== ref_hi) begin errors++; $display("FAIL dz_hi_kept: got %h want %h", hi, ref_hi); end
        checks++; if (lo !== ref_lo) begin errors++; $display("FAIL dz_lo_kept: got %h want %h", lo, ref_lo); end
        @(posedge clock); #1;
        checks++; if ({done, div_zero, busy} !== 3'b000)
            begin errors++; $display("FAIL dz_pulse_end: got %b want 000", {done, div_zero, busy}); end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, hi, lo;
        logic [1:0]   o;
        logic         dz, b0, edz;
        int           lat;
        for (int i = 0; i < 150; i++) begin
            o = 2'($urandom_range(0, 3));
            a = pick();
            b = pick();
            if (o[0] && $urandom_range(0, 9) == 0) b = '0;
            ref_op(o, a, b, edz);
            do_op(o, a, b, hi, lo, dz, lat, b0);
            checks++; if (lat !== (edz ? 1 : W + 1))
                begin errors++; $display("FAIL rnd%0d_latency op=%0d a=%h b=%h: got %0d want %0d", i, o, a, b, lat, edz ? 1 : W + 1); end
            checks++; if (dz !== edz)
                begin errors++; $display("FAIL rnd%0d_dz op=%0d a=%h b=%h: got %b want %b", i, o, a, b, dz, edz); end
            checks++; if (hi !== ref_hi)
                begin errors++; $display("FAIL rnd%0d_hi op=%0d a=%h b=%h: got %h want %h", i, o, a, b, hi, ref_hi); end
            checks++; if (lo !== ref_lo)
                begin errors++; $display("FAIL rnd%0d_lo op=%0d a=%h b=%h: got %h want %h", i, o, a, b, lo, ref_lo); end
        end
    endtask

    task automatic test_busy_start();
        logic edz;
        int   lat;
        wait_idle();
        ref_op(OP_MULT, 32'd123456, 32'hFFFFF000, edz);
        start = 1'b1; op = OP_MULT; a_in = 32'd123456; b_in = 32'hFFFFF000;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (5) begin @(posedge clock); #1; end
        start = 1'b1; op = OP_DIVU; a_in = 32'h1234; b_in = 32'h0;
        @(posedge clock); #1;
        start = 1'b0;
        lat = 6;
        while (!done && lat < 100) begin @(posedge clock); #1; lat++; end
        checks++; if (lat !== W + 1)     begin errors++; $display("FAIL busy_start_latency: got %0d want %0d", lat, W + 1); end
        checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL busy_start_dz: got %b want 0", div_zero); end
        checks++; if (hi_out !== ref_hi) begin errors++; $display("FAIL busy_start_hi: got %h want %h", hi_out, ref_hi); end
        checks++; if (lo_out !== ref_lo) begin errors++; $display("FAIL busy_start_lo: got %h want %h", lo_out, ref_lo); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_start_queued%0d: got %b want 0", i, busy); end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] hi, lo;
        logic         dz, b0, edz;
        int           lat;
        ref_op(OP_DIVU, 32'd1000, 32'd7, edz);
        do_op(OP_DIVU, 32'd1000, 32'd7, hi, lo, dz, lat, b0);
        ref_op(OP_MULTU, 32'hDEADBEEF, 32'h12345678, edz);
        start = 1'b1; op = OP_MULTU; a_in = 32'hDEADBEEF; b_in = 32'h12345678;
        @(posedge clock); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_start_on_done: got busy %b want 0", busy); end
        @(posedge clock); #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_start_next_idle: got busy %b want 1", busy); end
        start = 1'b0;
        lat = 0;
        while (!done && lat < 100) begin @(posedge clock); #1; lat++; end
        checks++; if (lat !== W + 1)     begin errors++; $display("FAIL b2b_latency: got %0d want %0d", lat, W + 1); end
        checks++; if (hi_out !== ref_hi) begin errors++; $display("FAIL b2b_hi: got %h want %h", hi_out, ref_hi); end
        checks++; if (lo_out !== ref_lo) begin errors++; $display("FAIL b2b_lo: got %h want %h", lo_out, ref_lo); end
    endtask

    task automatic test_reset_mid();
        wait_idle();
        start = 1'b1; op = OP_MULT; a_in = 32'd12345; b_in = 32'd678;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clock); #1; end
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        ref_hi = '0; ref_lo = '0;
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0)  begin errors++; $display("FAIL rst_mid_done: got %b want 0", done); end
        checks++; if (hi_out !== '0)  begin errors++; $display("FAIL rst_mid_hi: got %h want 0", hi_out); end
        checks++; if (lo_out !== '0)  begin errors++; $display("FAIL rst_mid_lo: got %h want 0", lo_out); end
        repeat (W + 2) begin @(posedge clock); #1; end
        checks++; if ({busy, done, hi_out, lo_out} !== '0)
            begin errors++; $display("FAIL rst_mid_no_resume: got busy=%b done=%b hi=%h lo=%h want all 0", busy, done, hi_out, lo_out); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div_zero();
        test_random();
        test_busy_start();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
